// File: rtl/dac_spi_serializer.sv
// Fixed-rate sampler that shifts {CFG_BITS, sample, 4'b0} to an MCP4901-style SPI DAC
// (mode 0, MSB first), then strobes LDAC and reports frame completion and dropped samples.
module dac_spi_serializer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SAMPLE_DIV = 625,
  parameter logic [3:0]  CFG_BITS   = 4'b0011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] sample_in,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_mosi,
  output logic       dac_ldac_n,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int unsigned RateW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [RateW-1:0] RateLast = RateW'(SAMPLE_DIV - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StShift, StHold, StGap, StLdac} state_e;

  state_e           state_q, state_d;
  logic [RateW-1:0] rate_cnt_q;
  logic [DivW-1:0]  div_q, div_d;
  logic             hi_q, hi_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      frame_q, frame_d;
  logic             done_q, done_d;
  logic             tick;
  logic             phase_end;

  assign tick      = enable && (rate_cnt_q == RateLast);
  assign phase_end = (div_q == DivLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_cnt_q <= '0;
    end else if (!enable || (rate_cnt_q == RateLast)) begin
      rate_cnt_q <= '0;
    end else begin
      rate_cnt_q <= rate_cnt_q + RateW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hi_d    = hi_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    if (state_q != StIdle) begin
      div_d = phase_end ? '0 : div_q + DivW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          frame_d = {CFG_BITS, sample_in, 4'b0000};
          bit_d   = 4'd15;
          hi_d    = 1'b0;
          div_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Each bit: low phase (mosi settles) then high phase (DAC samples on the rise).
        if (phase_end) begin
          if (!hi_q) begin
            hi_d = 1'b1;
          end else begin
            hi_d = 1'b0;
            if (bit_q == 4'd0) state_d = StHold;
            else               bit_d   = bit_q - 4'd1;
          end
        end
      end
      StHold: if (phase_end) state_d = StGap;
      StGap:  if (phase_end) state_d = StLdac;
      StLdac: begin
        if (phase_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dac_cs_n   = !((state_q == StShift) || (state_q == StHold));
  assign dac_sclk   = (state_q == StShift) && hi_q;
  assign dac_mosi   = (state_q == StShift) ? frame_q[bit_q] : 1'b0;
  assign dac_ldac_n = (state_q != StLdac);
  assign busy       = (state_q != StIdle);
  assign frame_done = done_q;
  // A tick that finds a frame in flight is dropped; frame_done cycle is already idle.
  assign overrun    = tick && busy;

endmodule
